frame_buffer_dbl: RTL and testbench



---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_bank_ram.sv | 43 ++++
 rtl/frame_buffer_dbl.sv | 154 +++++++++++++++
 tb/tb_frame_buffer_dbl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg : shared types, defaults and address packing for frame_buffer_dbl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  typedef enum logic [1:0] {
    RENDER    = 2'd0,
    SWAP_PEND = 2'd1,
    CLEAR     = 2'd2
  } fb_state_t;

  localparam int FB_H_PIXELS_DEF = 256;
  localparam int FB_V_PIXELS_DEF = 192;
  localparam int FB_PIXEL_W_DEF  = 12;

  // Packs {y, x} with x occupying the low xw bits; callers truncate to ADDR_W.
  function automatic logic [31:0] fb_addr(input logic [15:0] y, input logic [15:0] x,
                                          input int unsigned xw);
    return ({16'h0000, y} << xw) | {16'h0000, x};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fb_bank_ram.sv
// ---------------------------------------------------------------------------
// fb_bank_ram : one pixel bank, single write port and registered read port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fb_bank_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Only the output register is reset so the array itself stays RAM-inferable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/frame_buffer_dbl.sv
// ---------------------------------------------------------------------------
// frame_buffer_dbl : double-buffered pixel store with frame-synchronous swap
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_buffer_dbl
  import fb_pkg::*;
#(
  parameter int                 H_PIXELS      = FB_H_PIXELS_DEF,
  parameter int                 V_PIXELS      = FB_V_PIXELS_DEF,
  parameter int                 PIXEL_W       = FB_PIXEL_W_DEF,
  parameter logic [PIXEL_W-1:0] CLEAR_COLOR   = '0,
  parameter int                 CLEAR_ON_SWAP = 1,
  localparam int                XW            = $clog2(H_PIXELS),
  localparam int                YW            = $clog2(V_PIXELS),
  localparam int                ADDR_W        = YW + XW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid_i,
  output logic               wr_ready_o,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [PIXEL_W-1:0] wr_data_i,
  input  logic               swap_req_i,
  output logic               swap_ack_o,
  input  logic               frame_start_i,
  input  logic               rd_en_i,
  input  logic [ADDR_W-1:0]  rd_addr_i,
  output logic [PIXEL_W-1:0] rd_data_o,
  output logic               rd_valid_o,
  output logic               front_sel_o,
  output logic               clearing_o
);

  localparam logic [YW:0]   LP_V    = (YW+1)'(V_PIXELS);
  localparam logic [XW-1:0] LP_XMAX = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] LP_YMAX = YW'(V_PIXELS - 1);

  fb_state_t         state_q;
  logic              front_sel_q;
  logic              swap_ack_q;
  logic              clearing_q;
  logic              rd_sel_q;
  logic              rd_valid_q;
  logic [XW-1:0]     clr_x_q;
  logic [YW-1:0]     clr_y_q;

  logic              w_in_range;
  logic              w_clr_last;
  logic              w_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [ADDR_W-1:0] w_waddr;
  logic [PIXEL_W-1:0] w_wdata;
  logic [PIXEL_W-1:0] w_bank_rdata [2];

  assign wr_ready_o  = (state_q == RENDER);
  assign w_in_range  = ({1'b0, wr_addr_i[ADDR_W-1:XW]} < LP_V);
  assign w_clr_last  = (clr_x_q == LP_XMAX) && (clr_y_q == LP_YMAX);
  assign w_clr_addr  = ADDR_W'(fb_addr(16'(clr_y_q), 16'(clr_x_q), XW));

  // Out-of-range rows are handshaken but never reach the bank.
  assign w_we    = clearing_q || (wr_ready_o && wr_valid_i && w_in_range);
  assign w_waddr = clearing_q ? w_clr_addr : wr_addr_i;
  assign w_wdata = clearing_q ? CLEAR_COLOR : wr_data_i;

  // The first CLEAR cycle (swap_ack high) only arms clearing_q, so the
  // clear writes line up exactly with clearing_o being high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RENDER;
      front_sel_q <= 1'b0;
      swap_ack_q  <= 1'b0;
      clearing_q  <= 1'b0;
      clr_x_q     <= '0;
      clr_y_q     <= '0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state_q)
        RENDER: begin
          if (swap_req_i) begin
            state_q <= SWAP_PEND;
          end
        end
        SWAP_PEND: begin
          if (frame_start_i) begin
            front_sel_q <= ~front_sel_q;
            swap_ack_q  <= 1'b1;
            clr_x_q     <= '0;
            clr_y_q     <= '0;
            state_q     <= (CLEAR_ON_SWAP != 0) ? CLEAR : RENDER;
          end
        end
        CLEAR: begin
          if (!clearing_q) begin
            clearing_q <= 1'b1;
          end else if (w_clr_last) begin
            clearing_q <= 1'b0;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            state_q    <= RENDER;
          end else if (clr_x_q == LP_XMAX) begin
            clr_x_q <= '0;
            clr_y_q <= clr_y_q + 1'b1;
          end else begin
            clr_x_q <= clr_x_q + 1'b1;
          end
        end
        default: state_q <= RENDER;
      endcase
    end
  end

  // The bank choice travels alongside the read so a commit-cycle read sees the old front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i;
      if (rd_en_i) begin
        rd_sel_q <= front_sel_q;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      localparam logic LP_ID = 1'(gi);
      fb_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PIXEL_W)
      ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_we && (front_sel_q != LP_ID)),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .re_i    (rd_en_i),
        .raddr_i (rd_addr_i),
        .rdata_o (w_bank_rdata[gi])
      );
    end
  endgenerate

  assign rd_data_o   = w_bank_rdata[rd_sel_q];
  assign rd_valid_o  = rd_valid_q;
  assign swap_ack_o  = swap_ack_q;
  assign front_sel_o = front_sel_q;
  assign clearing_o  = clearing_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_buffer_dbl.sv
// ---------------------------------------------------------------------------
// tb_frame_buffer_dbl : directed table-driven bench for frame_buffer_dbl (8x6)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_buffer_dbl;

  localparam int          H   = 8;
  localparam int          V   = 6;
  localparam int          AW  = 6;
  localparam logic [11:0] CLR = 12'h5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid, wr_ready, swap_req, swap_ack, frame_start;
  logic        rd_en, rd_valid, front_sel, clearing;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [11:0] wr_data, rd_data;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   wdata;
    logic [11:0]   exp;
  } vec_t;

  vec_t tbl [8];

  frame_buffer_dbl #(
    .H_PIXELS      (H),
    .V_PIXELS      (V),
    .PIXEL_W       (12),
    .CLEAR_COLOR   (CLR),
    .CLEAR_ON_SWAP (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .swap_req_i    (swap_req),
    .swap_ack_o    (swap_ack),
    .frame_start_i (frame_start),
    .rd_en_i       (rd_en),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .front_sel_o   (front_sel),
    .clearing_o    (clearing)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] pa(input int y, input int x);
    return AW'(y * H + x);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic commit(input logic exp_front);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("swap_ack at commit", swap_ack, 1);
    chk("front_sel at commit", front_sel, exp_front);
  endtask

  task automatic read_px(input logic [AW-1:0] ad, output logic [11:0] d);
    rd_en   = 1'b1;
    rd_addr = ad;
    tick();
    rd_en = 1'b0;
    chk("rd_valid", rd_valid, 1);
    d = rd_data;
  endtask

  task automatic count_clear(inout int n);
    while (clearing && n < 200) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] d;
    int n;

    tbl[0] = '{pa(0,5), 12'hABC, 12'hABC};
    tbl[1] = '{pa(0,0), 12'h001, 12'h001};
    tbl[2] = '{pa(5,7), 12'hFFF, 12'hFFF};
    tbl[3] = '{pa(1,2), 12'h777, 12'h777};
    tbl[4] = '{pa(2,3), 12'h3C3, 12'h246};
    tbl[5] = '{pa(3,7), 12'h800, 12'h800};
    tbl[6] = '{pa(2,3), 12'h246, 12'h246};
    tbl[7] = '{pa(4,4), 12'h4E4, 12'h4E4};

    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    swap_req = 1'b0; frame_start = 1'b0; rd_en = 1'b0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wr_ready", wr_ready, 1);
    chk("reset front_sel", front_sel, 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset rd_valid", rd_valid, 0);
    chk("reset swap_ack", swap_ack, 0);
    chk("reset clearing", clearing, 0);
    rst_n = 1'b1;
    tick();

    // Row y=6 is beyond V: consumed but never stored.
    wr_valid = 1'b1; wr_addr = pa(6,0); wr_data = 12'h123;
    chk("oob wr_ready", wr_ready, 1);
    tick();

    // Last table write coincides with swap_req and must still land in the old back bank.
    for (int i = 0; i < 8; i++) begin
      wr_addr  = tbl[i].addr;
      wr_data  = tbl[i].wdata;
      swap_req = (i == 7);
      chk("table wr_ready", wr_ready, 1);
      tick();
    end
    wr_valid = 1'b0; swap_req = 1'b0;
    chk("pending wr_ready", wr_ready, 0);

    commit(1'b1);
    chk("wr_ready during clear start", wr_ready, 0);
    n = 0;
    tick();
    chk("swap_ack single pulse", swap_ack, 0);
    count_clear(n);
    chk("clearing cycle count", n, H * V);
    chk("wr_ready after clear", wr_ready, 1);

    for (int i = 0; i < 8; i++) begin
      read_px(tbl[i].addr, d);
      chk("table read", d, tbl[i].exp);
    end
    read_px(pa(6,0), d);
    chk("oob not stored", (d === 12'h123), 0);
    tick();
    chk("rd_valid idle", rd_valid, 0);
    chk("rd_data held", rd_data, d);

    wr_valid = 1'b1; wr_addr = pa(1,2); wr_data = 12'h111;
    tick();
    wr_valid = 1'b0;

    // Swap held pending for 10 cycles; stalled writes must not land.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_valid = 1'b1; wr_addr = pa(1,2); wr_data = 12'hBAD;
    for (int k = 0; k < 10; k++) begin
      chk("pend wr_ready", wr_ready, 0);
      tick();
    end
    wr_valid = 1'b0;
    chk("pend front_sel", front_sel, 1);
    chk("pend swap_ack", swap_ack, 0);

    // Read sampled in the commit cycle returns the old front bank.
    frame_start = 1'b1; rd_en = 1'b1; rd_addr = pa(1,2);
    tick();
    frame_start = 1'b0;
    chk("swap_ack commit2", swap_ack, 1);
    chk("front_sel commit2", front_sel, 0);
    chk("commit-cycle read old", rd_data, 12'h777);
    tick();
    rd_en = 1'b0;
    chk("next read new front", rd_data, 12'h111);
    n = 0;
    count_clear(n);
    chk("clearing count 2", n, H * V);
    read_px(pa(5,7), d);
    chk("cleared pixel bank0", d, CLR);

    // swap_req with frame_start in RENDER: commit waits for the next frame_start.
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("simul swap_ack", swap_ack, 0);
    chk("simul front_sel", front_sel, 0);
    chk("simul wr_ready", wr_ready, 0);
    repeat (3) tick();
    chk("simul still pending", front_sel, 0);
    commit(1'b1);
    n = 0;
    tick();
    count_clear(n);
    chk("clearing count 3", n, H * V);
    for (int p = 0; p < H * V; p++) begin
      read_px(AW'(p), d);
      chk("cleared bank1 pixel", d, CLR);
    end

    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    commit(1'b0);
    n = 0;
    tick();
    count_clear(n);

    // Async reset partway through a clear.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    commit(1'b1);
    repeat (5) tick();
    chk("mid clear active", clearing, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst clearing", clearing, 0);
    chk("async rst wr_ready", wr_ready, 1);
    chk("async rst front_sel", front_sel, 0);
    chk("async rst swap_ack", swap_ack, 0);
    chk("async rst rd_valid", rd_valid, 0);
    chk("async rst rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post rst wr_ready", wr_ready, 1);
    chk("post rst front_sel", front_sel, 0);
    chk("post rst clearing", clearing, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
